execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined ARM core, directly upstream of the memory stage. Selects forwarded operands, runs the ALU, evaluates the ARM condition field against the NZCV flags register, gates the instruction's side effects, and registers everything the memory stage consumes in the EX/MEM pipeline register. Stall and flush come from the hazard unit.

## Interface
Parameters:
- WIDTH, 32, datapath width; WIDTH < 2 is illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stallE  in  1  hold EX/MEM register and flags
- flushE  in  1  discard instruction in E (bubble into M)
- RD1E, RD2E  in  WIDTH  register-file operands
- ExtImmE  in  WIDTH  extended immediate
- ResultW  in  WIDTH  writeback-stage result (forward source)
- ALUResultMfwd  in  WIDTH  current ALUResultM (forward source)
- ForwardAE, ForwardBE  in  2  00 reg, 01 ResultW, 10 ALUResultMfwd, 11 reg
- ALUSrcE  in  1  1 = SrcB is ExtImmE
- ALUControlE  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- CondE  in  4  ARM condition field
- FlagWriteE  in  2  bit1 updates NZ, bit0 updates CV
- RegWriteE, MemWriteE, MemToRegE, PCSrcE, PlusOneE  in  1 each  decoded controls
- WA3E  in  4  destination register
- ALUResultM, WriteDataM  out  WIDTH  registered ALU result, store data (forwarded SrcB before immediate mux)
- WA3M  out  4  registered destination
- RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM  out  1 each  registered, condition-gated controls
- BranchTakenE  out  1  combinational: PCSrcE & CondExE & ~flushE
- FlagsQ  out  4  NZCV register (debug/verify)

## Operation
- SrcA = mux(ForwardAE); forwarded B = mux(ForwardBE); SrcB = ALUSrcE ? ExtImmE : forwarded B.
- ADD/SUB computed as a WIDTH+1-bit sum; SUB = SrcA + ~SrcB + 1.
- Flags: N = result[WIDTH-1]; Z = (result == 0); C = carry-out of WIDTH+1 sum (SUB: 1 = no borrow); V = operands same sign (B inverted for SUB) and result sign differs. AND/ORR: C = V = 0.
- CondExE from FlagsQ: EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 → 1; 1111 → 0.
- Gated controls: RegWrite, MemWrite, PCSrc, PlusOne are ANDed with CondExE; MemToReg is passed ungated (harmless without RegWrite).
- Flags update NZ when FlagWriteE[1] & CondExE, CV when FlagWriteE[0] & CondExE; never on stall or flush.

## Timing
- Latency 1 cycle E→M; BranchTakenE same cycle.
- Priority per edge: reset > flushE > stallE > load.
- reset: all M outputs 0, FlagsQ 0000.
- flushE (even with stallE): all M outputs 0 (bubble), flags unchanged.
- stallE alone: all M outputs and FlagsQ hold.
- Condition uses FlagsQ before this instruction's own update; flag writes are visible to the next instruction in E (back-to-back CMP/B works without a bubble).
- Reset asserted mid-stall clears everything; first edge after deassert loads normally.

## Structure
- Package arm_pkg: alu_op_t enum (ADD/SUB/AND/ORR), cond_t constants (EQ..AL, NV), fwd_sel_t (REG/WB/MEM).
- One sub-module: condcheck (CondE, FlagsQ → CondExE), purely combinational.
- EX/MEM register and flags register inline; no memories.

## Test plan
- Reset: hold reset 2 cycles with random inputs → every M output 0, FlagsQ 0000.
- SUB 5-5, FlagWriteE=11, CondE=AL → ALUResultM 0, FlagsQ 0110 (Z=1, C=1); next instruction CondE=EQ, RegWriteE=1 → RegWriteM 1; NE → RegWriteM 0.
- ADD 7FFFFFFF+1 flags 11 → result 80000000, FlagsQ 1001; ADD FFFFFFFF+1 → 0, FlagsQ 0110.
- Forwarding: RD1E=1, ALUResultMfwd=10, ResultW=20, SrcB imm 3; ForwardAE 10 → 13, 01 → 23; ForwardBE=10 with MemWriteE → WriteDataM = ALUResultMfwd.
- Stall then flush: load ADD, stallE 3 cycles → M outputs and FlagsQ frozen; stallE+flushE with flag-writing SUB → M all 0, FlagsQ unchanged.
- Branch: FlagsQ Z=1, PCSrcE=1, CondE=EQ → BranchTakenE 1 same cycle, PCSrcM 1 next; with flushE=1 → BranchTakenE 0, PCSrcM 0.

Source files
------------

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared types for the ARM pipeline execute stage: ALU
//                operation encoding, condition-field codes and forwarding
//                mux selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef logic [3:0] cond_t;

    localparam cond_t C_COND_EQ = 4'b0000;
    localparam cond_t C_COND_NE = 4'b0001;
    localparam cond_t C_COND_CS = 4'b0010;
    localparam cond_t C_COND_CC = 4'b0011;
    localparam cond_t C_COND_MI = 4'b0100;
    localparam cond_t C_COND_PL = 4'b0101;
    localparam cond_t C_COND_VS = 4'b0110;
    localparam cond_t C_COND_VC = 4'b0111;
    localparam cond_t C_COND_HI = 4'b1000;
    localparam cond_t C_COND_LS = 4'b1001;
    localparam cond_t C_COND_GE = 4'b1010;
    localparam cond_t C_COND_LT = 4'b1011;
    localparam cond_t C_COND_GT = 4'b1100;
    localparam cond_t C_COND_LE = 4'b1101;
    localparam cond_t C_COND_AL = 4'b1110;
    localparam cond_t C_COND_NV = 4'b1111;

    // Encoding 2'b11 is not named: it falls back to the register operand.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_if
//  Description : Bundle of the execute-stage hazard controls, E-stage
//                operands/controls and the EX/MEM register outputs.
//                master : drives the E-stage side, observes M outputs.
//                slave  : the execute stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_if #(
    parameter int WIDTH = 32
);
    // hazard unit
    logic             stallE;
    logic             flushE;
    // operands
    logic [WIDTH-1:0] RD1E;
    logic [WIDTH-1:0] RD2E;
    logic [WIDTH-1:0] ExtImmE;
    logic [WIDTH-1:0] ResultW;
    logic [WIDTH-1:0] ALUResultMfwd;
    // decoded controls
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ALUSrcE;
    logic [1:0]       ALUControlE;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemToRegE;
    logic             PCSrcE;
    logic             PlusOneE;
    logic [3:0]       WA3E;
    // EX/MEM register and status
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [3:0]       WA3M;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             MemToRegM;
    logic             PCSrcM;
    logic             PlusOneM;
    logic             BranchTakenE;
    logic [3:0]       FlagsQ;

    modport master (
        output stallE, flushE, RD1E, RD2E, ExtImmE, ResultW, ALUResultMfwd,
               ForwardAE, ForwardBE, ALUSrcE, ALUControlE, CondE, FlagWriteE,
               RegWriteE, MemWriteE, MemToRegE, PCSrcE, PlusOneE, WA3E,
        input  ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM,
               PCSrcM, PlusOneM, BranchTakenE, FlagsQ
    );

    modport slave (
        input  stallE, flushE, RD1E, RD2E, ExtImmE, ResultW, ALUResultMfwd,
               ForwardAE, ForwardBE, ALUSrcE, ALUControlE, CondE, FlagWriteE,
               RegWriteE, MemWriteE, MemToRegE, PCSrcE, PlusOneE, WA3E,
        output ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM,
               PCSrcM, PlusOneM, BranchTakenE, FlagsQ
    );

endinterface : execute_stage_if
`default_nettype wire

// File: rtl/condcheck.sv
`default_nettype none
// ============================================================================
//  Module      : condcheck
//  Description : ARM condition-field evaluation against the NZCV register.
//                Purely combinational.
//                CondE   [3:0] in  : condition field
//                FlagsQ  [3:0] in  : {N,Z,C,V}
//                CondExE       out : 1 = instruction executes
//  Revision    : 1.0 - initial release
// ============================================================================
module condcheck
    import arm_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsQ,
    output logic       CondExE
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = FlagsQ[3];
    assign w_z  = FlagsQ[2];
    assign w_c  = FlagsQ[1];
    assign w_v  = FlagsQ[0];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondExE = 1'b0;
        case (CondE)
            C_COND_EQ: CondExE = w_z;
            C_COND_NE: CondExE = ~w_z;
            C_COND_CS: CondExE = w_c;
            C_COND_CC: CondExE = ~w_c;
            C_COND_MI: CondExE = w_n;
            C_COND_PL: CondExE = ~w_n;
            C_COND_VS: CondExE = w_v;
            C_COND_VC: CondExE = ~w_v;
            C_COND_HI: CondExE = w_c & ~w_z;
            C_COND_LS: CondExE = ~w_c | w_z;
            C_COND_GE: CondExE = w_ge;
            C_COND_LT: CondExE = ~w_ge;
            C_COND_GT: CondExE = ~w_z & w_ge;
            C_COND_LE: CondExE = w_z | ~w_ge;
            C_COND_AL: CondExE = 1'b1;
            default:   CondExE = 1'b0;  // NV never executes
        endcase
    end

endmodule : condcheck
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Execute stage of the pipelined ARM core. Operand forwarding,
//                ALU, condition evaluation, side-effect gating, NZCV flags
//                register and the EX/MEM pipeline register.
//                clk, reset : clock, synchronous active-high reset
//                bus        : execute_stage_if.slave (hazard controls,
//                             E-stage inputs, M-stage outputs, FlagsQ,
//                             BranchTakenE)
//                WIDTH must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    execute_stage_if.slave      bus
);

    logic [WIDTH-1:0] w_srca;
    logic [WIDTH-1:0] w_fwdb;
    logic [WIDTH-1:0] w_srcb;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_is_sub;
    logic             w_is_arith;
    logic             w_n, w_z, w_c, w_v;
    logic             w_condex;
    logic [3:0]       w_flags_next;

    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_aluresult;
    logic [WIDTH-1:0] r_writedata;
    logic [3:0]       r_wa3;
    logic             r_regwrite;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic             r_pcsrc;
    logic             r_plusone;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    always_comb begin
        case (fwd_sel_t'(bus.ForwardAE))
            FWD_WB:  w_srca = bus.ResultW;
            FWD_MEM: w_srca = bus.ALUResultMfwd;
            default: w_srca = bus.RD1E;
        endcase
    end

    always_comb begin
        case (fwd_sel_t'(bus.ForwardBE))
            FWD_WB:  w_fwdb = bus.ResultW;
            FWD_MEM: w_fwdb = bus.ALUResultMfwd;
            default: w_fwdb = bus.RD2E;
        endcase
    end

    assign w_srcb = bus.ALUSrcE ? bus.ExtImmE : w_fwdb;

    // ------------------------------------------------------------------
    // ALU: SUB is SrcA + ~SrcB + 1, so the carry-out reads as "no borrow".
    // ------------------------------------------------------------------
    assign w_is_sub   = (alu_op_t'(bus.ALUControlE) == ALU_SUB);
    assign w_is_arith = ~bus.ALUControlE[1];
    assign w_bop      = w_is_sub ? ~w_srcb : w_srcb;
    assign w_sum      = {1'b0, w_srca} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_is_sub};

    always_comb begin
        case (alu_op_t'(bus.ALUControlE))
            ALU_AND: w_result = w_srca & w_srcb;
            ALU_ORR: w_result = w_srca | w_srcb;
            default: w_result = w_sum[WIDTH-1:0];
        endcase
    end

    assign w_n = w_result[WIDTH-1];
    assign w_z = (w_result == '0);
    assign w_c = w_is_arith & w_sum[WIDTH];
    // Overflow: operands (B already inverted for SUB) agree in sign but the
    // result does not.
    assign w_v = w_is_arith & (w_srca[WIDTH-1] == w_bop[WIDTH-1])
                            & (w_result[WIDTH-1] != w_srca[WIDTH-1]);

    // ------------------------------------------------------------------
    // Condition check uses the flags as they stand before this
    // instruction's own update.
    // ------------------------------------------------------------------
    condcheck u_condcheck (
        .CondE   (bus.CondE),
        .FlagsQ  (r_flags),
        .CondExE (w_condex)
    );

    always_comb begin
        w_flags_next = r_flags;
        if (bus.FlagWriteE[1] && w_condex) begin
            w_flags_next[3:2] = {w_n, w_z};
        end
        if (bus.FlagWriteE[0] && w_condex) begin
            w_flags_next[1:0] = {w_c, w_v};
        end
    end

    // ------------------------------------------------------------------
    // Flags register: cleared by reset, frozen by flush or stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (!bus.flushE && !bus.stallE) begin
            r_flags <= w_flags_next;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register: flush inserts a bubble even while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || bus.flushE) begin
            r_aluresult <= '0;
            r_writedata <= '0;
            r_wa3       <= 4'd0;
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_plusone   <= 1'b0;
        end else if (!bus.stallE) begin
            r_aluresult <= w_result;
            r_writedata <= w_fwdb;
            r_wa3       <= bus.WA3E;
            r_regwrite  <= bus.RegWriteE & w_condex;
            r_memwrite  <= bus.MemWriteE & w_condex;
            r_memtoreg  <= bus.MemToRegE;
            r_pcsrc     <= bus.PCSrcE    & w_condex;
            r_plusone   <= bus.PlusOneE  & w_condex;
        end
    end

    assign bus.ALUResultM   = r_aluresult;
    assign bus.WriteDataM   = r_writedata;
    assign bus.WA3M         = r_wa3;
    assign bus.RegWriteM    = r_regwrite;
    assign bus.MemWriteM    = r_memwrite;
    assign bus.MemToRegM    = r_memtoreg;
    assign bus.PCSrcM       = r_pcsrc;
    assign bus.PlusOneM     = r_plusone;
    assign bus.FlagsQ       = r_flags;
    assign bus.BranchTakenE = bus.PCSrcE & w_condex & ~bus.flushE;

endmodule : execute_stage
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage: a table of directed
//                vectors applied back to back, plus hand-written reset,
//                stall/flush and mid-stall reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;

    execute_stage_if #(.WIDTH(WIDTH)) bus ();

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        alusrc;
        logic [1:0]  op;
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic [31:0] rd1, rd2, imm, resw, mfwd;
        logic        rw, mw, pcs;
        logic [31:0] e_res, e_wd;
        logic        e_rw, e_mw, e_pcs, e_bt;
        logic [3:0]  e_flags;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.stallE = 0; bus.flushE = 0;
        bus.RD1E = 0; bus.RD2E = 0; bus.ExtImmE = 0; bus.ResultW = 0; bus.ALUResultMfwd = 0;
        bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUSrcE = 0; bus.ALUControlE = 0;
        bus.CondE = 4'b1110; bus.FlagWriteE = 0;
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.MemToRegE = 0; bus.PCSrcE = 0; bus.PlusOneE = 0;
        bus.WA3E = 0;
    endtask

    task automatic alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fw, input logic [3:0] cond);
        bus.ALUControlE = op; bus.RD1E = a; bus.RD2E = b; bus.FlagWriteE = fw; bus.CondE = cond;
        bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUSrcE = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".ALUResultM"}, bus.ALUResultM, 0);
        chk({tag, ".WriteDataM"}, bus.WriteDataM, 0);
        chk({tag, ".WA3M"},       {28'd0, bus.WA3M}, 0);
        chk({tag, ".ctrlM"},      {27'd0, bus.RegWriteM, bus.MemWriteM, bus.MemToRegM,
                                   bus.PCSrcM, bus.PlusOneM}, 0);
    endtask

    function automatic vec_t mk(logic [1:0] fa, logic [1:0] fb, logic alusrc, logic [1:0] op,
                                logic [3:0] cond, logic [1:0] fw, logic [31:0] rd1,
                                logic [31:0] rd2, logic [31:0] imm, logic [31:0] resw,
                                logic [31:0] mfwd, logic rw, logic mw, logic pcs,
                                logic [31:0] e_res, logic [31:0] e_wd, logic e_rw,
                                logic e_mw, logic e_pcs, logic e_bt, logic [3:0] e_flags);
        vec_t v;
        v.fa = fa; v.fb = fb; v.alusrc = alusrc; v.op = op; v.cond = cond; v.fw = fw;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw; v.mfwd = mfwd;
        v.rw = rw; v.mw = mw; v.pcs = pcs;
        v.e_res = e_res; v.e_wd = e_wd; v.e_rw = e_rw; v.e_mw = e_mw; v.e_pcs = e_pcs;
        v.e_bt = e_bt; v.e_flags = e_flags;
        return v;
    endfunction

    initial begin
        // ---------------- table: applied back to back, flags carry over ----
        //         fa fb src op  cond     fw  rd1           rd2  imm resw mfwd rw mw pc  res           wd   rw mw pc bt flags
        vt.push_back(mk(0, 0, 0, 1, 4'b1110, 3, 32'd5,        5,   0,  0,   0,  1, 0, 0, 32'd0,        5,   1, 0, 0, 0, 4'b0110)); // SUB 5-5
        vt.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 32'd1,        2,   0,  0,   0,  1, 0, 0, 32'd3,        2,   1, 0, 0, 0, 4'b0110)); // EQ taken
        vt.push_back(mk(0, 0, 0, 0, 4'b0001, 0, 32'd1,        2,   0,  0,   0,  1, 0, 0, 32'd3,        2,   0, 0, 0, 0, 4'b0110)); // NE not taken
        vt.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 32'd0,        0,   0,  0,   0,  0, 0, 1, 32'd0,        0,   0, 0, 1, 1, 4'b0110)); // branch EQ
        vt.push_back(mk(0, 0, 0, 0, 4'b1110, 3, 32'h7FFFFFFF, 1,   0,  0,   0,  0, 0, 0, 32'h80000000, 1,   0, 0, 0, 0, 4'b1001)); // overflow
        vt.push_back(mk(0, 0, 0, 0, 4'b1110, 3, 32'hFFFFFFFF, 1,   0,  0,   0,  0, 0, 0, 32'd0,        1,   0, 0, 0, 0, 4'b0110)); // carry, zero
        vt.push_back(mk(2, 0, 1, 0, 4'b1110, 0, 32'd1,        7,   3, 20,  10,  0, 0, 0, 32'd13,       7,   0, 0, 0, 0, 4'b0110)); // fwd A=MEM
        vt.push_back(mk(1, 0, 1, 0, 4'b1110, 0, 32'd1,        7,   3, 20,  10,  0, 0, 0, 32'd23,       7,   0, 0, 0, 0, 4'b0110)); // fwd A=WB
        vt.push_back(mk(0, 2, 1, 0, 4'b1110, 0, 32'd1,        7,   3, 20,  10,  0, 1, 0, 32'd4,        10,  0, 1, 0, 0, 4'b0110)); // fwd B store
        vt.push_back(mk(3, 3, 0, 2, 4'b1110, 3, 32'hF0,   32'h3C,  0,  9,   9,  0, 0, 0, 32'h30,   32'h3C,  0, 0, 0, 0, 4'b0000)); // AND, sel 11
        vt.push_back(mk(0, 0, 0, 3, 4'b1110, 2, 32'd0,        0,   0,  0,   0,  0, 0, 0, 32'd0,        0,   0, 0, 0, 0, 4'b0100)); // ORR NZ only
        vt.push_back(mk(0, 0, 0, 1, 4'b1011, 3, 32'd3,        5,   0,  0,   0,  1, 0, 0, 32'hFFFFFFFE, 5,   0, 0, 0, 0, 4'b0100)); // LT false: no update
        vt.push_back(mk(0, 0, 0, 1, 4'b1110, 3, 32'd3,        5,   0,  0,   0,  0, 0, 0, 32'hFFFFFFFE, 5,   0, 0, 0, 0, 4'b1000)); // SUB 3-5 borrow
        vt.push_back(mk(0, 0, 0, 0, 4'b1010, 0, 32'd0,        0,   0,  0,   0,  1, 0, 0, 32'd0,        0,   0, 0, 0, 0, 4'b1000)); // GE false
        vt.push_back(mk(0, 0, 0, 0, 4'b1011, 0, 32'd0,        0,   0,  0,   0,  1, 0, 0, 32'd0,        0,   1, 0, 0, 0, 4'b1000)); // LT true
        vt.push_back(mk(0, 0, 0, 0, 4'b1111, 0, 32'd0,        0,   0,  0,   0,  1, 0, 1, 32'd0,        0,   0, 0, 0, 0, 4'b1000)); // NV never

        // ---------------- reset with random inputs -------------------------
        idle();
        reset = 1;
        repeat (2) begin
            @(negedge clk);
            bus.RD1E = $urandom; bus.RD2E = $urandom; bus.ExtImmE = $urandom;
            bus.ALUControlE = 2'($urandom_range(0, 3)); bus.CondE = 4'b1110;
            bus.RegWriteE = 1; bus.MemWriteE = 1; bus.MemToRegE = 1; bus.PCSrcE = 1;
            bus.PlusOneE = 1; bus.WA3E = 4'($urandom); bus.FlagWriteE = 3;
        end
        step();
        chk_m_zero("reset");
        chk("reset.FlagsQ", {28'd0, bus.FlagsQ}, 0);
        reset = 0;
        idle();

        // ---------------- table vectors ------------------------------------
        for (int i = 0; i < vt.size(); i++) begin
            bus.ForwardAE = vt[i].fa; bus.ForwardBE = vt[i].fb; bus.ALUSrcE = vt[i].alusrc;
            bus.ALUControlE = vt[i].op; bus.CondE = vt[i].cond; bus.FlagWriteE = vt[i].fw;
            bus.RD1E = vt[i].rd1; bus.RD2E = vt[i].rd2; bus.ExtImmE = vt[i].imm;
            bus.ResultW = vt[i].resw; bus.ALUResultMfwd = vt[i].mfwd;
            bus.RegWriteE = vt[i].rw; bus.MemWriteE = vt[i].mw; bus.PCSrcE = vt[i].pcs;
            #1;
            chk($sformatf("v%0d.BranchTakenE", i), {31'd0, bus.BranchTakenE}, {31'd0, vt[i].e_bt});
            step();
            chk($sformatf("v%0d.ALUResultM", i), bus.ALUResultM, vt[i].e_res);
            chk($sformatf("v%0d.WriteDataM", i), bus.WriteDataM, vt[i].e_wd);
            chk($sformatf("v%0d.ctrlM", i), {29'd0, bus.RegWriteM, bus.MemWriteM, bus.PCSrcM},
                {29'd0, vt[i].e_rw, vt[i].e_mw, vt[i].e_pcs});
            chk($sformatf("v%0d.FlagsQ", i), {28'd0, bus.FlagsQ}, {28'd0, vt[i].e_flags});
        end

        // ---------------- stall then flush ---------------------------------
        idle();
        alu(2'b00, 32'h7FFFFFFF, 32'd1, 2'b11, 4'b1110);
        bus.RegWriteE = 1; bus.WA3E = 4'd9; bus.PlusOneE = 1;
        step();
        chk("load.ALUResultM", bus.ALUResultM, 32'h80000000);
        chk("load.FlagsQ", {28'd0, bus.FlagsQ}, 32'h9);
        chk("load.WA3M", {28'd0, bus.WA3M}, 9);
        chk("load.PlusOneM", {31'd0, bus.PlusOneM}, 1);
        alu(2'b01, 32'd5, 32'd5, 2'b11, 4'b1110);
        bus.WA3E = 4'd3; bus.RegWriteE = 0; bus.PlusOneE = 0;
        bus.stallE = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d.ALUResultM", k), bus.ALUResultM, 32'h80000000);
            chk($sformatf("stall%0d.ctrlM", k), {28'd0, bus.WA3M, bus.RegWriteM, bus.PlusOneM},
                {28'd0, 4'd9, 1'b1, 1'b1});
            chk($sformatf("stall%0d.FlagsQ", k), {28'd0, bus.FlagsQ}, 32'h9);
        end
        bus.flushE = 1; bus.RegWriteE = 1; bus.PCSrcE = 1; bus.MemToRegE = 1;
        #1;
        chk("stallflush.BranchTakenE", {31'd0, bus.BranchTakenE}, 0);
        step();
        chk_m_zero("stallflush");
        chk("stallflush.FlagsQ", {28'd0, bus.FlagsQ}, 32'h9);

        // ---------------- branch with flush --------------------------------
        idle();
        alu(2'b01, 32'd5, 32'd5, 2'b11, 4'b1110);
        step();
        chk("cmp.FlagsQ", {28'd0, bus.FlagsQ}, 32'h6);
        idle();
        bus.PCSrcE = 1; bus.CondE = 4'b0000;
        #1;
        chk("branch.BranchTakenE", {31'd0, bus.BranchTakenE}, 1);
        bus.flushE = 1;
        #1;
        chk("branchflush.BranchTakenE", {31'd0, bus.BranchTakenE}, 0);
        step();
        chk("branchflush.PCSrcM", {31'd0, bus.PCSrcM}, 0);

        // ---------------- reset mid-stall ----------------------------------
        idle();
        alu(2'b00, 32'd1, 32'd2, 2'b11, 4'b1110);
        bus.RegWriteE = 1; bus.WA3E = 4'd5;
        step();
        chk("pre.ALUResultM", bus.ALUResultM, 3);
        bus.stallE = 1;
        step();
        reset = 1;
        step();
        chk_m_zero("midreset");
        chk("midreset.FlagsQ", {28'd0, bus.FlagsQ}, 0);
        reset = 0; bus.stallE = 0;
        alu(2'b00, 32'd4, 32'd6, 2'b11, 4'b1110);
        step();
        chk("postreset.ALUResultM", bus.ALUResultM, 10);
        chk("postreset.RegWriteM", {31'd0, bus.RegWriteM}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_execute_stage
`default_nettype wire
